// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI mode-0 responder modelling an 8-channel 12-bit A2D.
// Decodes channel commands from MOSI and returns the latched channel's sample on MISO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI  raw SPI inputs from the link master (oversampled)
//   MISO              registered slave-out data, MSB first, 0 outside a frame
//   chan_data         NUM_CH packed samples, ch k at [DATA_W*k +: DATA_W]
//   cur_chnl          channel latched by the last valid command frame
//   cmd_vld           1-clk pulse when a 16-bit frame completes
//   xfer_err          1-clk pulse when a frame ends with a bit count other than 16
//   busy              high while a frame is being shifted
//
// Build option: define A2D_CH_ID_EN to place the responding channel number
// in response bits [15:13]; otherwise bits [15:12] are zero.

module a2d_spi_resp #(
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16,
  parameter int NUM_CH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SS_n,
  input  logic                     SCLK,
  input  logic                     MOSI,
  output logic                     MISO,
  input  logic [NUM_CH*DATA_W-1:0] chan_data,
  output logic [2:0]               cur_chnl,
  output logic                     cmd_vld,
  output logic                     xfer_err,
  output logic                     busy
);

  localparam int PAD_W = FRAME_W - DATA_W;
  localparam int CNT_W = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;

  // [0],[1] form the synchroniser, [2] is the edge-detect history
  logic [2:0] ss_q;
  logic [2:0] sclk_q;
  logic [2:0] mosi_q;

  logic [FRAME_W-1:0] tx_shft;
  logic [FRAME_W-1:0] rx_shft;
  logic [CNT_W-1:0]   bit_cnt;

  logic ss_fall;
  logic ss_rise;
  logic sclk_rise;
  logic sclk_fall;

  assign ss_fall   =  ss_q[2]   & ~ss_q[1];
  assign ss_rise   = ~ss_q[2]   &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

  logic [DATA_W-1:0] samples [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign samples[k] = chan_data[k*DATA_W +: DATA_W];
  end

  logic [DATA_W-1:0]  sel_sample;
  logic [FRAME_W-1:0] tx_load;

  assign sel_sample = samples[cur_chnl];

`ifdef A2D_CH_ID_EN
  assign tx_load = {cur_chnl, {(PAD_W-3){1'b0}}, sel_sample};
`else
  assign tx_load = {{PAD_W{1'b0}}, sel_sample};
`endif

  // Command field positions inside the received frame
  logic [1:0] rx_op;
  logic [2:0] rx_ch;

  assign rx_op = rx_shft[FRAME_W-1 -: 2];
  assign rx_ch = rx_shft[FRAME_W-3 -: 3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_IDLE;
      ss_q     <= '0;
      sclk_q   <= '0;
      mosi_q   <= '0;
      tx_shft  <= '0;
      rx_shft  <= '0;
      bit_cnt  <= '0;
      MISO     <= 1'b0;
      cur_chnl <= '0;
      cmd_vld  <= 1'b0;
      xfer_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ss_q     <= {ss_q[1:0], SS_n};
      sclk_q   <= {sclk_q[1:0], SCLK};
      mosi_q   <= {mosi_q[1:0], MOSI};
      cmd_vld  <= 1'b0;
      xfer_err <= 1'b0;

      unique case (state)
        // Never join a frame already in flight; wait for SS_n high
        WAIT_IDLE: begin
          MISO <= 1'b0;
          busy <= 1'b0;
          if (ss_q[1]) begin
            state <= IDLE;
          end
        end

        // SCLK edges are not looked at here, so an edge that
        // coincides with the SS_n fall is dropped
        IDLE: begin
          MISO <= 1'b0;
          if (ss_fall) begin
            tx_shft <= tx_load;
            MISO    <= tx_load[FRAME_W-1];
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          // MOSI is stable well before the rise, so the
          // older history flop is a safe sample point
          if (sclk_rise) begin
            rx_shft <= {rx_shft[FRAME_W-2:0], mosi_q[2]};
            if (bit_cnt != CNT_SAT) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          // Zero fill drives MISO low once all bits are out
          if (sclk_fall) begin
            tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
            MISO    <= tx_shft[FRAME_W-2];
          end
          // A rise on the same cycle was already counted above
          if (ss_rise) begin
            MISO  <= 1'b0;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          MISO  <= 1'b0;
          state <= IDLE;
          if (bit_cnt == CNT_FULL) begin
            cmd_vld <= 1'b1;
            if (rx_op == 2'b00) begin
              cur_chnl <= rx_ch;
            end
          end else begin
            xfer_err <= 1'b1;
          end
        end

        default: begin
          state <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- SPI responder (slave) model of the 8-channel, 12-bit A2D converter that sits on the other end of the pot-slider SPI link.
- Decodes channel commands from the link master, returns 12-bit samples on MISO, and lets the slider interface be exercised and checked in simulation and FPGA loopback.
- Samples come from a parallel input bus driven by a bench or a test pattern source.
- SPI mode 0; all SPI inputs are oversampled in the clk domain.

Parameters:
- DATA_W, 12, sample width per channel.
- FRAME_W, 16, bits per SPI transaction.
- NUM_CH, 8, number of channels. Fixed at 8, because the command channel field is 3 bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- SS_n  input  1  SPI slave select, active-low
- SCLK  input  1  SPI clock, idles low
- MOSI  input  1  master-out data, MSB first
- MISO  output  1  slave-out data, MSB first
- chan_data  input  96  channel samples; ch k occupies bits [12k+11:12k]
- cur_chnl  output  3  channel latched by the last valid command
- cmd_vld  output  1  one-clk pulse when a valid 16-bit frame completes
- xfer_err  output  1  one-clk pulse when a frame ends with bit count not equal to 16
- busy  output  1  high while a frame is in progress (SHIFT state)

Behaviour:
- Reset: one clock and one synchronous active-high reset; all flops clear on rst high at posedge clk.
  - Output reset values: MISO=0, cur_chnl=0, cmd_vld=0, xfer_err=0, busy=0.
  - Internal state after reset: state=WAIT_IDLE, bit_cnt=0, shift regs=0.
- Input synchronisation:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchroniser, then a 3rd flop for edge detect.
  - Edge-detect latency is 3 clk.
  - Master requirement: SCLK half-period ≥ 4 clk, and the first SCLK rise ≥ 4 clk after SS_n fall.
- State machine:
  - WAIT_IDLE: wait for synced SS_n high, then go to IDLE. This prevents joining a frame mid-stream after reset.
  - IDLE: on SS_n fall:
    - tx_shft ← {4'h0, sample[cur_chnl]}, captured from chan_data in that cycle;
    - MISO ← tx_shft MSB;
    - bit_cnt ← 0;
    - go to SHIFT.
  - SHIFT:
    - SCLK rise: rx_shft ← {rx_shft[14:0], MOSI_sync}; bit_cnt increments and saturates at 17.
    - SCLK fall: tx_shft shifts left with 0 fill; MISO ← new MSB.
    - After 16 bits MISO outputs 0.
    - SS_n rise: go to DONE.
  - DONE (1 clk), then IDLE:
    - If bit_cnt==16 and rx_shft[15:14]==2'b00: cur_chnl ← rx_shft[13:11]; pulse cmd_vld. rx_shft[10:0] is don't-care.
    - If bit_cnt==16 and rx_shft[15:14]!=2'b00: cmd_vld pulses; cur_chnl is unchanged.
    - If bit_cnt!=16: pulse xfer_err; cur_chnl is unchanged.
- Pipelining: each frame returns the sample of the channel latched by the previous frame. This matches the real converter, so a read is two frames: a command frame, then a data frame.
- Edge handling:
  - SCLK edges while SS_n high are ignored.
  - An SCLK edge coinciding with the SS_n fall is ignored.
  - An SCLK rise coinciding with the SS_n rise still counts.
- MISO is held at 0 whenever not in SHIFT (there is no tri-state).
- Sample capture: chan_data is sampled only at the SS_n fall. Changes during a frame do not affect the MISO bits.
- rst high mid-frame: everything resets, and the state machine waits in WAIT_IDLE for SS_n high before accepting a frame.

Optional Feature:
- Macro: A2D_CH_ID_EN.
- Defined: response bits [15:13] carry the channel the sample belongs to (the cur_chnl value at SS_n fall); bit 12 stays 0.
- Undefined: bits [15:12] are 0.
- Sample bits [11:0] are identical in both cases.

Test Plan:
- Reset then frame: rst for 2 clk, chan_data ch0=12'hABC, send frame 16'h0000 → MISO returns 16'h0ABC; cmd_vld pulses; cur_chnl=0.
- Channel select pipeline: ch5=12'h5A5, send 16'h2800 then 16'h2800 → first response is ch0 data, second is 16'h05A5; cur_chnl=5. With A2D_CH_ID_EN defined, second response is 16'hA5A5.
- Short frame: SS_n low, 10 SCLK pulses, SS_n high → xfer_err one pulse, no cmd_vld, cur_chnl unchanged.
- Long frame: 18 SCLK pulses → xfer_err; MISO=0 on bits 17-18.
- Mid-frame reset: assert rst after 7 bits while SS_n is still low, finish the frame → no cmd_vld and no xfer_err; the next full frame after SS_n high works normally.
- Data stability: change ch0 from 12'h123 to 12'hFFF during a frame → response is 16'h0123; the next frame returns 12'hFFF; SCLK pulses while SS_n high produce no pulses on any output.
